// File: rtl/pipe_addsub.sv
// Pipelined add/subtract unit: one SEG_W-bit carry segment per register stage, latency STAGES.
// Result and flags are registered at the last stage and advance under a single global enable.
module pipe_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             lt_u,
  output logic             lt_s
);

  localparam int unsigned STAGES = WIDTH / SEG_W;
  localparam int unsigned LAST   = STAGES - 1;

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic             op_q    [STAGES];
  logic             op_d    [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];

  logic cout_q, cout_d;
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;
  logic neg_q, neg_d;
  logic ltu_q, ltu_d;
  logic lts_q, lts_d;

  logic             adv;
  logic [WIDTH-1:0] a_in, b_in;
  logic [SEG_W:0]   seg;
  logic             msb_cin;

  function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] x,
                                             input logic [SEG_W-1:0] y,
                                             input logic             c);
    return {1'b0, x} + {1'b0, y} + {{SEG_W{1'b0}}, c};
  endfunction

  always_comb begin
    adv      = ~valid_q[LAST] | out_ready;
    in_ready = adv;

    // Stage 0 takes operands straight from the ports; subtract is a + ~b + 1.
    a_in       = a;
    b_in       = op_sub ? ~b : b;
    seg        = seg_add(a_in[SEG_W-1:0], b_in[SEG_W-1:0], op_sub);
    valid_d[0] = in_valid & adv;
    op_d[0]    = op_sub;
    a_d[0]     = a_in;
    b_d[0]     = b_in;
    carry_d[0] = seg[SEG_W];
    sum_d[0]   = '0;
    sum_d[0][SEG_W-1:0] = seg[SEG_W-1:0];

    for (int unsigned k = 1; k < STAGES; k++) begin
      a_in       = a_q[k-1];
      b_in       = b_q[k-1];
      seg        = seg_add(a_in[k*SEG_W +: SEG_W], b_in[k*SEG_W +: SEG_W], carry_q[k-1]);
      valid_d[k] = valid_q[k-1];
      op_d[k]    = op_q[k-1];
      a_d[k]     = a_in;
      b_d[k]     = b_in;
      carry_d[k] = seg[SEG_W];
      sum_d[k]   = sum_q[k-1];
      sum_d[k][k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
    end

    // a_in/b_in now hold the last stage's operands; recover the carry into the MSB.
    msb_cin = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ sum_d[LAST][WIDTH-1];
    cout_d  = carry_d[LAST];
    ovf_d   = msb_cin ^ cout_d;
    zero_d  = (sum_d[LAST] == '0);
    neg_d   = sum_d[LAST][WIDTH-1];
    ltu_d   = op_d[LAST] & ~cout_d;
    lts_d   = op_d[LAST] & (neg_d ^ ovf_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        op_q[k]    <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ltu_q  <= 1'b0;
      lts_q  <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        op_q[k]    <= op_d[k];
        carry_q[k] <= carry_d[k];
        sum_q[k]   <= sum_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
      end
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ltu_q  <= ltu_d;
      lts_q  <= lts_d;
    end
  end

  assign out_valid = valid_q[LAST];
  assign result    = sum_q[LAST];
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign lt_u      = ltu_q;
  assign lt_s      = lts_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: three widths (32/8, 16/4, 64/16, all four stages) share one stimulus
// stream and are checked every cycle against an arithmetic reference model.
module tb_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        op_sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [31:0] res0;
  logic [15:0] res1;
  logic [63:0] res2;
  wire  [5:0]  fl0, fl1, fl2;  // {carry_out, overflow, zero, negative, lt_u, lt_s}

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(32), .SEG_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .op_sub(op_sub),
    .a(a[31:0]), .b(b[31:0]), .out_valid(ov0), .out_ready(out_ready), .result(res0),
    .carry_out(fl0[5]), .overflow(fl0[4]), .zero(fl0[3]), .negative(fl0[2]),
    .lt_u(fl0[1]), .lt_s(fl0[0])
  );

  pipe_addsub #(.WIDTH(16), .SEG_W(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .op_sub(op_sub),
    .a(a[15:0]), .b(b[15:0]), .out_valid(ov1), .out_ready(out_ready), .result(res1),
    .carry_out(fl1[5]), .overflow(fl1[4]), .zero(fl1[3]), .negative(fl1[2]),
    .lt_u(fl1[1]), .lt_s(fl1[0])
  );

  pipe_addsub #(.WIDTH(64), .SEG_W(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(ov2), .out_ready(out_ready), .result(res2),
    .carry_out(fl2[5]), .overflow(fl2[4]), .zero(fl2[3]), .negative(fl2[2]),
    .lt_u(fl2[1]), .lt_s(fl2[0])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {result[63:0], carry, ovf, zero, neg, lt_u, lt_s} from plain integer arithmetic.
  function automatic logic [69:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input logic sub);
    logic [63:0] mask, am, bm, res;
    logic [64:0] wide;
    logic        sa, sb, sr, cy, ov, lts;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = x & mask;
    bm   = y & mask;
    res  = (sub ? am - bm : am + bm) & mask;
    wide = {1'b0, am} + {1'b0, bm};
    cy   = sub ? (am >= bm) : wide[w];
    sa   = am[w-1];
    sb   = bm[w-1];
    sr   = res[w-1];
    ov   = sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
    lts  = (sa != sb) ? sa : (am < bm);
    return {res, cy, ov, (res == 64'd0), sr, sub & (am < bm), sub & lts};
  endfunction

  // Four slots of in-flight beats; all slots move together whenever the output can drain.
  typedef struct packed {
    logic        v;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
  } beat_t;
  beat_t pipe [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) pipe[i] <= '0;
    end else if (!pipe[3].v || out_ready) begin
      pipe[0] <= {in_valid, op_sub, a, b};
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [63:0] r  [3];
      logic [5:0]  f  [3];
      logic        v  [3];
      logic        rd [3];
      logic [69:0] e;
      int          wd;
      r[0] = {32'h0, res0}; r[1] = {48'h0, res1}; r[2] = res2;
      f[0] = fl0;  f[1] = fl1;  f[2] = fl2;
      v[0] = ov0;  v[1] = ov1;  v[2] = ov2;
      rd[0] = rdy0; rd[1] = rdy1; rd[2] = rdy2;
      for (int d = 0; d < 3; d++) begin
        wd = (d == 0) ? 32 : (d == 1) ? 16 : 64;
        chk($sformatf("in_ready_w%0d", wd), {63'h0, rd[d]}, {63'h0, (!pipe[3].v || out_ready)});
        chk($sformatf("out_valid_w%0d", wd), {63'h0, v[d]}, {63'h0, pipe[3].v});
        if (pipe[3].v) begin
          e = model(wd, pipe[3].a, pipe[3].b, pipe[3].sub);
          chk($sformatf("result_w%0d", wd), r[d], e[69:6]);
          chk($sformatf("flags_w%0d", wd), {58'h0, f[d]}, {58'h0, e[5:0]});
        end
      end
    end
  end

  task automatic rand_beat();
    a      = {$urandom, $urandom};
    b      = {$urandom, $urandom};
    op_sub = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) b = a;
    if ($urandom_range(0, 7) == 0) a = '1;
  endtask

  // One beat with out_ready held high; checks latency and the 32-bit outputs against literals.
  task automatic directed(input string name, input logic [31:0] da, input logic [31:0] db,
                          input logic dsub, input logic [31:0] er, input logic [5:0] ef);
    int n;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = {32'h0, da};
    b         = {32'h0, db};
    op_sub    = dsub;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) in_valid = 1'b0;
    end while (!ov0 && n < 20);
    chk({name, "_latency"}, 64'(n), 64'd4);
    chk({name, "_result"}, {32'h0, res0}, {32'h0, er});
    chk({name, "_flags"}, {58'h0, fl0}, {58'h0, ef});
  endtask

  // mode 0: out_ready pattern 1,0,0,1; mode 1: full throughput; mode 2: random valid/ready.
  task automatic stream(input int nbeats, input int mode);
    int   sent;
    int   cyc;
    logic acc;
    sent = 0;
    cyc  = 0;
    rand_beat();
    in_valid = 1'b1;
    while (sent < nbeats && cyc < 3000) begin
      case (mode)
        0:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 2 && !in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        if (in_valid) rand_beat();
      end
      @(negedge clk);
      acc = in_valid & rdy0;
      if (mode == 1) chk("tput_in_ready", {63'h0, rdy0}, 64'd1);
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        rand_beat();
        if (mode == 2) in_valid = ($urandom_range(0, 1) != 0);
      end
    end
    chk($sformatf("stream%0d_beats", mode), 64'(sent), 64'(nbeats));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", {61'h0, ov0, ov1, ov2}, 64'd0);
    chk("rst_in_ready", {61'h0, rdy0, rdy1, rdy2}, 64'd7);
    chk("rst_result", res2 | {32'h0, res0} | {48'h0, res1}, 64'd0);
    chk("rst_flags", {46'h0, fl0, fl1, fl2}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    directed("carry_ripple", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 6'b101000);
    directed("sub_borrow", 32'h3, 32'h5, 1'b1, 32'hFFFF_FFFE, 6'b000111);
    directed("sub_minneg", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 6'b110001);
    directed("sub_zero_b", 32'h5, 32'h0, 1'b1, 32'h5, 6'b100000);
    directed("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 6'b010100);
    directed("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0, 6'b101000);

    // Reset with three beats in flight, then the first post-reset beat.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {61'h0, ov0, ov1, ov2}, 64'd0);
    chk("midrst_in_ready", {61'h0, rdy0, rdy1, rdy2}, 64'd7);
    repeat (2) @(negedge clk);
    chk("midrst_held", {61'h0, ov0, ov1, ov2}, 64'd0);
    rst_n = 1'b1;
    directed("post_reset", 32'h7, 32'h5, 1'b0, 32'd12, 6'b000000);

    stream(6, 0);
    stream(100, 1);
    stream(300, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
